// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, y, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, y, cout, ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - carry-chunked pipelined adder/subtractor with valid/ready flow control
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    pipe_adder_if.slave bus
);
    localparam int CHUNK = (STAGES >= 1 && STAGES <= WIDTH) ? WIDTH / STAGES : 1;

    generate
        if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
            $error("pipe_adder: STAGES must be in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  acc_q [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] v_ch;
    logic [STAGES-1:0] c_ch;
    logic [STAGES-1:0] c_nx;
    logic [WIDTH-1:0]  acc_ch [STAGES];
    logic [WIDTH-1:0]  a_ch   [STAGES];
    logic [WIDTH-1:0]  b_ch   [STAGES];
    logic [WIDTH-1:0]  acc_nx [STAGES];
    logic              fire;

    // A stage may advance if it, or any stage downstream of it, has a hole.
    always_comb begin
        logic any_empty;
        any_empty = 1'b0;
        adv       = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            any_empty = any_empty | ~v_q[k];
            adv[k]    = any_empty | bus.out_ready;
        end
    end

    assign bus.in_ready = reset_n & ~flush & adv[0];
    assign fire         = bus.in_valid & bus.in_ready;

    // Element k of each *_ch array is what feeds stage k.
    always_comb begin
        logic [CHUNK:0] s;
        s         = '0;
        c_ch      = '0;
        c_nx      = '0;
        v_ch      = '0;
        a_ch[0]   = bus.a;
        b_ch[0]   = bus.b ^ {WIDTH{bus.sub}};
        acc_ch[0] = '0;
        c_ch[0]   = bus.sub;
        v_ch[0]   = fire;
        for (int k = 1; k < STAGES; k++) begin
            a_ch[k]   = a_q[k-1];
            b_ch[k]   = b_q[k-1];
            acc_ch[k] = acc_q[k-1];
            c_ch[k]   = c_q[k-1];
            v_ch[k]   = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            s = {1'b0, a_ch[k][k*CHUNK +: CHUNK]}
              + {1'b0, b_ch[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_ch[k]};
            acc_nx[k]                  = acc_ch[k];
            acc_nx[k][k*CHUNK +: CHUNK] = s[CHUNK-1:0];
            c_nx[k]                    = s[CHUNK];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                acc_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k]   <= v_ch[k];
                    c_q[k]   <= c_nx[k];
                    acc_q[k] <= acc_nx[k];
                    a_q[k]   <= a_ch[k];
                    b_q[k]   <= b_ch[k];
                end
            end
            if (flush) begin
                v_q <= '0;
            end
        end
    end

    // Operand MSBs ride along in a_q/b_q so overflow is judged on the last stage.
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.y         = acc_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                         & (acc_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; the carry chain is split into STAGES equal chunks of WIDTH/STAGES bits.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; one clock, asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1, synchronous clear of all in-flight operations.
REQ-006 SHALL have port in_valid, input, 1, operation offered on a, b and sub.
REQ-007 SHALL have port in_ready, output, 1, block accepts the offered operation this cycle.
REQ-008 SHALL have port a, input, WIDTH, first operand.
REQ-009 SHALL have port b, input, WIDTH, second operand.
REQ-010 SHALL have port sub, input, 1, mode: 0 = a+b, 1 = a-b.
REQ-011 SHALL have port out_valid, output, 1, result present on y/cout/ovf.
REQ-012 SHALL have port out_ready, input, 1, consumer takes the result this cycle.
REQ-013 SHALL have port y, output, WIDTH, sum/difference modulo 2^WIDTH.
REQ-014 SHALL have port cout, output, 1, carry out of MSB (for sub: 1 = no borrow).
REQ-015 SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-016 SHALL fail elaboration if STAGES < 1, STAGES > WIDTH, or WIDTH mod STAGES != 0.
REQ-017 SHALL compute a + (b XOR {WIDTH{sub}}) + sub, i.e. subtraction as a + ~b + 1.
REQ-018 SHALL, in stage k (0-based), add chunk k of both operands plus the carry registered by stage k-1 (stage 0 carry-in = sub), register the chunk result and carry-out, and forward the remaining upper operand chunks unchanged.
REQ-019 SHALL have a per-stage valid bit; an operation is accepted on the cycle in_valid && in_ready.
REQ-020 SHALL present the result exactly STAGES cycles after acceptance when out_ready is held high.
REQ-021 SHALL accept one operation per cycle (full throughput) while out_ready is high.
REQ-022 SHALL advance stage k when stage k is empty or stage k+1 advances; the last stage advances when out_valid is 0 or out_ready is 1.
REQ-023 SHALL drive in_ready = stage-0 advance condition; in_ready SHALL NOT depend on in_valid.
REQ-024 SHALL hold y, cout, ovf and out_valid stable while out_valid && !out_ready.
REQ-025 SHALL preserve order: results leave in acceptance order with no loss or duplication under any out_ready pattern.
REQ-026 SHALL compute ovf = (a[MSB] == b'[MSB]) && (y[MSB] != a[MSB]), with b' the possibly-inverted b, carrying both MSBs in the pipeline.
REQ-027 SHALL, on flush=1, clear all stage valid bits at the next edge, drop in-flight results, and force in_ready=0 that cycle (no acceptance concurrent with flush).
REQ-028 SHALL, with STAGES=1, behave as a registered adder with latency 1.

Reset
REQ-029 SHALL, while reset_n=0, asynchronously clear all valid bits; out_valid=0, in_ready=0, y=0, cout=0, ovf=0.
REQ-030 SHALL assert in_ready=1 on the first rising edge after reset_n deasserts, provided flush=0.
REQ-031 SHALL discard any operation in flight when reset asserts mid-operation; no result appears after release.

Verification
REQ-032 WIDTH=32, STAGES=4: a=0x0000_00FF, b=0x0000_0001, sub=0, out_ready=1 -> out_valid 4 cycles later, y=0x0000_0100, cout=0, ovf=0.
REQ-033 Carry across all chunks: a=0xFFFF_FFFF, b=0x0000_0001, sub=0 -> y=0x0000_0000, cout=1, ovf=0; a=0x7FFF_FFFF, b=1 -> y=0x8000_0000, ovf=1.
REQ-034 Subtract: a=5, b=7, sub=1 -> y=0xFFFF_FFFE, cout=0; a=0x8000_0000, b=1, sub=1 -> y=0x7FFF_FFFF, ovf=1, cout=1.
REQ-035 Backpressure: stream 10 random ops back-to-back, out_ready toggled pseudo-randomly -> all 10 results match reference model in order, in_ready drops only when pipeline full and stalled, y stable during stall.
REQ-036 Flush and reset mid-flight: accept 3 ops, assert flush -> out_valid=0 next cycle, none emitted; repeat with reset_n pulsed low -> outputs zero immediately, nothing emitted after release.
REQ-037 Sweep STAGES in {1,2,8,32} with WIDTH=32 -> latency equals STAGES and exhaustive-random checks match the model.
